// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit, then shifts a byte
// out on device clock falls and checks the device ACK. Both pins are driven open-drain via OEs.
//   state     | meaning
//   IDLE      | lines released, waiting for tx_start
//   INHIBIT   | clock held low for CLK_INHIBIT cycles
//   REQ       | start bit driven, clock released
//   SEND      | data/parity/stop presented on device clock falls
//   ACK       | waiting for the device ACK fall
//   WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx #(
    parameter int CLK_INHIBIT = 1200,
    parameter int TIMEOUT     = 24000
) (
    input  logic       CLOCK,
    input  logic       RESET_L,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CNT_W = 15;
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(CLK_INHIBIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       bitcnt, bitcnt_nxt;
    logic [9:0]       shift, shift_nxt;
    logic             clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, error_nxt;
    logic             ck_m, ck_s, ck_s_prev, dt_m, dt_s;
    logic             fall, timed_out;

    // Synchronisers reset to the idle-high bus level so reset never fabricates a fall.
    always_ff @(posedge CLOCK or negedge RESET_L) begin
        if (!RESET_L) begin
            ck_m      <= 1'b1;
            ck_s      <= 1'b1;
            ck_s_prev <= 1'b1;
            dt_m      <= 1'b1;
            dt_s      <= 1'b1;
        end else begin
            ck_m      <= PS2_CLK_IN;
            ck_s      <= ck_m;
            ck_s_prev <= ck_s;
            dt_m      <= PS2_DATA_IN;
            dt_s      <= dt_m;
        end
    end

    assign fall      = ck_s_prev & ~ck_s;
    assign timed_out = (cnt == TIMEOUT_LAST);

    always_ff @(posedge CLOCK or negedge RESET_L) begin
        if (!RESET_L) begin
            state       <= IDLE;
            cnt         <= '0;
            bitcnt      <= '0;
            shift       <= '0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bitcnt      <= bitcnt_nxt;
            shift       <= shift_nxt;
            PS2_CLK_OE  <= clk_oe_nxt;
            PS2_DATA_OE <= data_oe_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bitcnt_nxt  = bitcnt;
        shift_nxt   = shift;
        clk_oe_nxt  = PS2_CLK_OE;
        data_oe_nxt = PS2_DATA_OE;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;

        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (tx_start) begin
                    shift_nxt  = {1'b1, ~^tx_data, tx_data};
                    busy_nxt   = 1'b1;
                    clk_oe_nxt = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == INHIBIT_LAST) begin
                    data_oe_nxt = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                clk_oe_nxt = 1'b0;
                cnt_nxt    = '0;
                bitcnt_nxt = '0;
                state_nxt  = SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
                if (state == WAIT_IDLE && ck_s && dt_s) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (fall) begin
                    cnt_nxt = '0;
                    if (state == SEND) begin
                        data_oe_nxt = ~shift[0];
                        shift_nxt   = {1'b0, shift[9:1]};
                        bitcnt_nxt  = bitcnt + 1'b1;
                        if (bitcnt == 4'd9)
                            state_nxt = ACK;
                    end else if (state == ACK) begin
                        if (!dt_s) begin
                            state_nxt = WAIT_IDLE;
                        end else begin
                            error_nxt   = 1'b1;
                            busy_nxt    = 1'b0;
                            clk_oe_nxt  = 1'b0;
                            data_oe_nxt = 1'b0;
                            state_nxt   = IDLE;
                        end
                    end
                end else if (timed_out) begin
                    error_nxt   = 1'b1;
                    busy_nxt    = 1'b0;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
